// File: rtl/demux_1_to_4_stream_pkg.sv
// Shared types for the 1-to-N stream demux.
// Lane state encoding and counter width.
package demux_pkg;

  localparam int DEMUX_CNT_W = 8;

  typedef logic [DEMUX_CNT_W-1:0] cnt_t;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

endpackage

// File: rtl/demux_1_to_4_stream_if.sv
// Stream bundle for the 1-to-N demux.
// DEMUX_COUNT_EN adds per-lane delivery counters.
interface demux_1_to_4_stream_if #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 1
);
  import demux_pkg::*;

  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;
  logic                      sel_err;
`ifdef DEMUX_COUNT_EN
  logic [N_OUT*DEMUX_CNT_W-1:0] lane_count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err,
    input  lane_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err,
    output lane_count
  );
`else
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
`endif

endinterface

// File: rtl/demux_1_to_4_stream_lane.sv
// One output lane: single-word holding slot.
// DEMUX_COUNT_EN adds a wrapping delivery counter.
module demux_lane
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
`ifdef DEMUX_COUNT_EN
  output cnt_t              o_count,
`endif
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  lane_state_e       r_state;
  lane_state_e       w_next;
  logic [DATA_W-1:0] r_data;
  logic              w_drain;

  assign o_valid = (r_state == LANE_FULL);
  assign o_data  = r_data;
  assign w_drain = o_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LANE_EMPTY;
    else     r_state <= w_next;
  end

  // Load wins over drain so a refill in the drain cycle leaves no bubble.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LANE_EMPTY: if (i_load) w_next = LANE_FULL;
      LANE_FULL:  if (i_ready && !i_load) w_next = LANE_EMPTY;
      default:    w_next = LANE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

`ifdef DEMUX_COUNT_EN
  cnt_t r_count;

  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_count <= '0;
    else if (w_drain) r_count <= r_count + cnt_t'(1);
  end
`else
  logic w_unused;
  assign w_unused = w_drain;
`endif

endmodule

// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-N stream demux with per-lane slots.
// DEMUX_COUNT_EN exposes per-lane delivery counts.
module demux_1_to_4_stream
  import demux_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 1
) (
  input logic                  clk,
  input logic                  rst,
  demux_1_to_4_stream_if.slave bus
);

  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int NP    = 1 << SEL_W;

  logic [NP-1:0]           w_vld_pad;
  logic [NP-1:0]           w_rdy_pad;
  logic                    w_sel_ok;
  logic                    w_lane_rdy;
  logic                    w_accept;
  logic [N_OUT-1:0]        w_load;
  logic [N_OUT-1:0]        w_valid;
  logic [N_OUT*DATA_W-1:0] w_data;
  logic                    r_sel_err;

  // Pad to a power of two so any in_sel indexes safely.
  assign w_vld_pad  = NP'(w_valid);
  assign w_rdy_pad  = NP'(bus.out_ready);
  assign w_sel_ok   = {1'b0, bus.in_sel} < (SEL_W+1)'(N_OUT);
  assign w_lane_rdy = !w_vld_pad[bus.in_sel] || w_rdy_pad[bus.in_sel];

  assign bus.in_ready  = !w_sel_ok || w_lane_rdy;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;
  assign bus.sel_err   = r_sel_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sel_err <= 1'b0;
    else     r_sel_err <= w_accept && !w_sel_ok;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign w_load[k] = w_accept && w_sel_ok &&
                       (bus.in_sel == SEL_W'(k));

    demux_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (bus.in_data),
      .i_ready (bus.out_ready[k]),
`ifdef DEMUX_COUNT_EN
      .o_count (bus.lane_count[k*DEMUX_CNT_W +: DEMUX_CNT_W]),
`endif
      .o_valid (w_valid[k]),
      .o_data  (w_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Directed bench: N_OUT=4/DATA_W=1 and N_OUT=3/DATA_W=8.
// Counter checks run when DEMUX_COUNT_EN is defined.
module tb_demux_1_to_4_stream;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  demux_1_to_4_stream_if #(.N_OUT(4), .DATA_W(1)) a ();
  demux_1_to_4_stream_if #(.N_OUT(3), .DATA_W(8)) b ();

  demux_1_to_4_stream #(.N_OUT(4), .DATA_W(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  demux_1_to_4_stream #(.N_OUT(3), .DATA_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_a(input logic [1:0] sel, input logic d);
    a.in_valid = 1'b1;
    a.in_sel   = sel;
    a.in_data  = d;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    a.in_valid  = 1'b0;
    a.in_data   = '0;
    a.in_sel    = '0;
    a.out_ready = '0;
    b.in_valid  = 1'b0;
    b.in_data   = '0;
    b.in_sel    = '0;
    b.out_ready = '0;
    #3;
    check_eq("rst_valid", 32'(a.out_valid), 32'h0);
    check_eq("rst_data", 32'(a.out_data), 32'h0);
    check_eq("rst_selerr", 32'(a.sel_err), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // sweep
    a.out_ready = 4'hF;
    send_a(2'd0, 1'b1);
    step();
    check_eq("sweep0", 32'(a.out_valid), 32'h1);
    a.in_sel = 2'd1;
    step();
    check_eq("sweep1", 32'(a.out_valid), 32'h2);
    a.in_sel = 2'd2;
    step();
    check_eq("sweep2", 32'(a.out_valid), 32'h4);
    a.in_sel = 2'd3;
    step();
    check_eq("sweep3", 32'(a.out_valid), 32'h8);
    a.in_valid = 1'b0;
    step();
    check_eq("sweep_idle", 32'(a.out_valid), 32'h0);
    check_eq("sweep_data", 32'(a.out_data), 32'hF);

    // backpressure on lane 1
    a.out_ready = 4'b1101;
    send_a(2'd1, 1'b1);
    #2;
    check_eq("bp_rdy1", 32'(a.in_ready), 32'h1);
    step();
    check_eq("bp_full1", 32'(a.out_valid), 32'h2);
    send_a(2'd1, 1'b0);
    #2;
    check_eq("bp_stall", 32'(a.in_ready), 32'h0);
    step();
    check_eq("bp_hold_v", 32'(a.out_valid), 32'h2);
    check_eq("bp_hold_d", 32'(a.out_data[1]), 32'h1);
    send_a(2'd3, 1'b0);
    #2;
    check_eq("bp_rdy3", 32'(a.in_ready), 32'h1);
    step();
    check_eq("bp_both", 32'(a.out_valid), 32'hA);
    check_eq("bp_d3", 32'(a.out_data[3]), 32'h0);
    a.in_valid = 1'b0;
    step();
    check_eq("bp_drain3", 32'(a.out_valid), 32'h2);
    a.out_ready = 4'hF;
    step();
    check_eq("bp_drain1", 32'(a.out_valid), 32'h0);

    // same-cycle load and drain on lane 0
    a.out_ready = 4'b1110;
    send_a(2'd0, 1'b0);
    step();
    a.in_valid = 1'b0;
    step();
    check_eq("ld_full0", 32'(a.out_valid), 32'h1);
    check_eq("ld_d0_old", 32'(a.out_data[0]), 32'h0);
    a.out_ready = 4'hF;
    send_a(2'd0, 1'b1);
    #2;
    check_eq("ld_rdy0", 32'(a.in_ready), 32'h1);
    step();
    check_eq("ld_nogap", 32'(a.out_valid), 32'h1);
    check_eq("ld_d0_new", 32'(a.out_data[0]), 32'h1);
    a.in_valid = 1'b0;
    step();
    check_eq("ld_empty", 32'(a.out_valid), 32'h0);

    // async reset with lane 2 stalled
    a.out_ready = 4'b1011;
    send_a(2'd2, 1'b1);
    step();
    a.in_valid = 1'b0;
    step();
    check_eq("mr_full2", 32'(a.out_valid), 32'h4);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_valid", 32'(a.out_valid), 32'h0);
    check_eq("mr_data", 32'(a.out_data), 32'h0);
    for (int s = 0; s < 4; s++) begin
      a.in_sel = 2'(s);
      #1;
      check_eq($sformatf("mr_rdy%0d", s), 32'(a.in_ready), 32'h1);
    end
    #1;
    rst = 1'b0;
    step();

`ifdef DEMUX_COUNT_EN
    a.out_ready = 4'hF;
    send_a(2'd2, 1'b1);
    repeat (257) step();
    a.in_valid = 1'b0;
    step();
    step();
    check_eq("cnt_lanes", 32'(a.lane_count), 32'h0001_0000);
`endif

    // N_OUT=3, DATA_W=8
    b.out_ready = 3'b000;
    b.in_valid  = 1'b1;
    b.in_sel    = 2'd1;
    b.in_data   = 8'h3C;
    step();
    check_eq("b_full1", 32'(b.out_valid), 32'h2);
    b.in_sel  = 2'd3;
    b.in_data = 8'hA5;
    #2;
    check_eq("b_rdy_oor", 32'(b.in_ready), 32'h1);
    step();
    check_eq("b_selerr", 32'(b.sel_err), 32'h1);
    check_eq("b_oor_v", 32'(b.out_valid), 32'h2);
    check_eq("b_oor_d", 32'(b.out_data), 32'h003C00);
    b.in_valid = 1'b0;
    step();
    check_eq("b_selerr_off", 32'(b.sel_err), 32'h0);
    b.in_valid = 1'b1;
    b.in_sel   = 2'd2;
    b.in_data  = 8'h5A;
    step();
    b.in_valid = 1'b0;
    check_eq("b_full2_v", 32'(b.out_valid), 32'h6);
    check_eq("b_full2_d", 32'(b.out_data), 32'h5A3C00);
    check_eq("b_selerr_n", 32'(b.sel_err), 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
